// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin writeback arbiter for the single register-file write port (optional WB_LOAD_PRIORITY_EN)
module wb_port_arbiter #(
    parameter int LQ_DEPTH = 2,
    parameter int XLEN     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    output logic                        alu_ready,
    input  logic                        ld_valid,
    input  logic [4:0]                  ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    output logic                        ld_ready,
    input  logic                        md_valid,
    input  logic [4:0]                  md_rd,
    input  logic [XLEN-1:0]             md_data,
    output logic                        md_ready,
    output logic                        rf_we,
    output logic [4:0]                  rf_waddr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

    logic [4:0]      lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data [LQ_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      ptr;
    logic [2:0]      cand;
    logic [2:0]      rr_idx;
    logic            gnt_valid;
    logic [1:0]      gnt;
    logic            push;
    logic            pop;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Requests are masked while reset is low so nothing is accepted then.
    assign cand      = {md_valid, (count != '0), alu_valid} & {3{reset}};
    assign ld_ready  = reset && (count < DEPTH_C);
    assign push      = ld_valid && ld_ready;
    assign pop       = gnt_valid && (gnt == 2'd1);
    assign alu_ready = gnt_valid && (gnt == 2'd0);
    assign md_ready  = gnt_valid && (gnt == 2'd2);
    assign lq_count  = count;

    // Grant selection: first valid candidate in search order starting at ptr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = 2'd0;
        rr_idx    = 3'd0;
`ifdef WB_LOAD_PRIORITY_EN
        if (cand[1]) begin
            gnt_valid = 1'b1;
            gnt       = 2'd1;
        end else if (ptr == 2'd0) begin
            if (cand[0]) begin
                gnt_valid = 1'b1;
                gnt       = 2'd0;
            end else if (cand[2]) begin
                gnt_valid = 1'b1;
                gnt       = 2'd2;
            end
        end else begin
            if (cand[2]) begin
                gnt_valid = 1'b1;
                gnt       = 2'd2;
            end else if (cand[0]) begin
                gnt_valid = 1'b1;
                gnt       = 2'd0;
            end
        end
`else
        // Walk from the farthest slot back to ptr so the nearest valid one is kept.
        for (int i = 2; i >= 0; i--) begin
            rr_idx = {1'b0, ptr} + 3'(i);
            if (rr_idx >= 3'd3) begin
                rr_idx = rr_idx - 3'd3;
            end
            if (cand[rr_idx[1:0]]) begin
                gnt_valid = 1'b1;
                gnt       = rr_idx[1:0];
            end
        end
`endif
    end

    // Route the granted source's destination and data to the output register.
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        case (gnt)
            2'd1: begin
                sel_rd   = lq_rd[rd_ptr];
                sel_data = lq_data[rd_ptr];
            end
            2'd2: begin
                sel_rd   = md_rd;
                sel_data = md_data;
            end
            default: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
        endcase
    end

    // Load-queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= ld_rd;
            lq_data[wr_ptr] <= ld_data;
        end
    end

    // Load-queue pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Round-robin pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 2'd0;
        end else if (gnt_valid) begin
`ifdef WB_LOAD_PRIORITY_EN
            if (gnt == 2'd0) begin
                ptr <= 2'd2;
            end else if (gnt == 2'd2) begin
                ptr <= 2'd0;
            end
`else
            ptr <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
`endif
        end
    end

    // Registered write port; x0 writes are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (gnt_valid) begin
            rf_we    <= (sel_rd != 5'd0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter with a queue-based reference model
module tb_wb_port_arbiter;
    localparam int LQ_DEPTH = 2;
    localparam int XLEN     = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            md_valid;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_data;
    logic            md_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [$clog2(LQ_DEPTH):0] lq_count;

    wb_port_arbiter #(.LQ_DEPTH(LQ_DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .lq_count(lq_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    int              errors = 0;
    int              checks = 0;
    ent_t            mq[$];
    int              mptr;
    logic            m_we;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    int              last_g;
    int              last_qsize;
    bit              acc_alu, acc_md, acc_ld;
    bit              obs_alu_rdy;
    bit              saw_full, saw_block, saw_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        bit v[3];
        int r;
        if (!reset) return -1;
        v[0] = alu_valid;
        v[1] = (mq.size() > 0);
        v[2] = md_valid;
`ifdef WB_LOAD_PRIORITY_EN
        if (v[1]) return 1;
        r = mptr;
        if (v[r]) return r;
        r = (mptr == 0) ? 2 : 0;
        if (v[r]) return r;
`else
        for (int k = 0; k < 3; k++) begin
            r = (mptr + k) % 3;
            if (v[r]) return r;
        end
`endif
        return -1;
    endfunction

    // One clock cycle: check combinational outputs, step the model at the edge, check registered outputs.
    task automatic cycle();
        int   g;
        bit   exp_ldr;
        bit   push;
        ent_t e;
        #1;
        g       = model_grant();
        exp_ldr = reset && (mq.size() < LQ_DEPTH);
        push    = ld_valid && exp_ldr;
        chk("alu_ready", alu_ready, (g == 0));
        chk("md_ready", md_ready, (g == 2));
        chk("ld_ready", ld_ready, exp_ldr);
        chk("lq_count", lq_count, mq.size());
        obs_alu_rdy = alu_ready;
        if (lq_count == LQ_DEPTH) saw_full = 1;
        if (reset && !ld_ready) saw_block = 1;
        last_g     = g;
        last_qsize = mq.size();
        acc_alu    = (g == 0);
        acc_md     = (g == 2);
        acc_ld     = push;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            mptr   = 0;
            m_we   = 0;
            m_addr = 0;
            m_data = 0;
        end else begin
            if (g >= 0) begin
                if (g == 0)      e = '{alu_rd, alu_data};
                else if (g == 2) e = '{md_rd, md_data};
                else             e = mq.pop_front();
                m_we   = (e.rd != 0);
                m_addr = e.rd;
                m_data = e.data;
`ifdef WB_LOAD_PRIORITY_EN
                if (g == 0) mptr = 2;
                else if (g == 2) mptr = 0;
`else
                mptr = (g + 1) % 3;
`endif
            end else begin
                m_we = 0;
            end
            if (push) mq.push_back('{ld_rd, ld_data});
        end
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        if (rf_we && (rf_waddr == 5'd7 || rf_waddr == 5'd8)) saw_bad = 1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; ld_valid = 0; md_valid = 0;
    endtask

    initial begin
        reset = 0; idle_inputs();
        alu_rd = 0; alu_data = 0; ld_rd = 0; ld_data = 0; md_rd = 0; md_data = 0;
        mptr = 0; m_we = 0; m_addr = 0; m_data = 0;
        @(posedge clk);
        #1;

        // Reset held with every source valid, then released.
        alu_valid = 1; ld_valid = 1; md_valid = 1;
        alu_rd = 5'd1; ld_rd = 5'd2; md_rd = 5'd3;
        do_reset(3);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_lq_count", lq_count, 0);
        cycle();
        chk("first_grant_alu", last_g, 0);

        // Single ALU write.
        idle_inputs();
        do_reset(1);
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cycle();
        chk("single_alu_ready", obs_alu_rdy, 1);
        chk("single_we", rf_we, 1);
        chk("single_addr", rf_waddr, 5);
        chk("single_data", rf_wdata, 32'hDEADBEEF);
        alu_valid = 0;
        cycle();
        chk("single_we_drop", rf_we, 0);

        // All sources continuously valid with a load offered every cycle.
        do_reset(1);
        saw_full = 0; saw_block = 0;
        alu_valid = 1; md_valid = 1; ld_valid = 1;
        alu_rd = 5'd10; md_rd = 5'd20; ld_rd = 5'd1;
        for (int i = 0; i < 12; i++) begin
            cycle();
`ifndef WB_LOAD_PRIORITY_EN
            chk("rr_seq", last_g, i % 3);
`else
            chk("prio_ld_wins", (last_g == 1), (last_qsize > 0));
`endif
            if (acc_alu) begin alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom; end
            if (acc_md)  begin md_rd  = 5'($urandom_range(1, 31)); md_data  = $urandom; end
            if (acc_ld)  begin ld_rd  = ld_rd + 5'd1; ld_data = $urandom; end
        end
`ifndef WB_LOAD_PRIORITY_EN
        chk("saw_full", saw_full, 1);
        chk("saw_ld_block", saw_block, 1);
`endif

        // rd=0 request is consumed silently and the pointer moves on to the queue.
        idle_inputs();
        do_reset(1);
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h5555AAAA;
        cycle();
        chk("rd0_alu_ready", obs_alu_rdy, 1);
        chk("rd0_no_we", rf_we, 0);
        alu_rd = 5'd4; ld_valid = 0; md_valid = 1; md_rd = 5'd6;
        cycle();
`ifndef WB_LOAD_PRIORITY_EN
        chk("rd0_next_grant_ld", last_g, 1);
`endif
        chk("rd0_ld_addr", rf_waddr, 9);
        idle_inputs();

        // Two queued loads discarded by reset.
        do_reset(1);
        saw_bad = 0;
        md_valid = 1; md_rd = 5'd12; ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h7777;
        cycle();
        md_valid = 0; alu_valid = 1; alu_rd = 5'd3; ld_rd = 5'd8; ld_data = 32'h8888;
        cycle();
`ifndef WB_LOAD_PRIORITY_EN
        chk("flush_count_before", lq_count, 2);
`endif
        idle_inputs();
        do_reset(1);
        chk("flush_count_after", lq_count, 0);
        repeat (4) cycle();
`ifndef WB_LOAD_PRIORITY_EN
        chk("flush_no_x7_x8", saw_bad, 0);
`endif

        // Randomized traffic with occasional reset pulses.
        acc_alu = 1; acc_md = 1; acc_ld = 1;
        for (int n = 0; n < 500; n++) begin
            if (acc_alu || !alu_valid) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
            end
            if (acc_md || !md_valid) begin
                md_valid = ($urandom_range(0, 2) == 0);
                md_rd = 5'($urandom_range(0, 31)); md_data = $urandom;
            end
            if (acc_ld || !ld_valid) begin
                ld_valid = ($urandom_range(0, 1) != 0);
                ld_rd = 5'($urandom_range(0, 31)); ld_data = $urandom;
            end
            reset = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
